// File: rtl/wis_pkg.sv
// Shared definitions for the score-RAM write-port manager and the score-RAM reader:
// the score word width, the port-width helpers and the cell-to-linear-address mapping.
package wis_pkg;

  localparam int SCORE_W = 9;

  // Width of an index port, able to hold 0..n.
  function automatic int idx_w(input int n);
    return $clog2(n) + 1;
  endfunction

  // Width of the linear address port of an (n+1)x(n+1) matrix.
  function automatic int addr_w(input int n);
    return (n + 1) * (n + 1);
  endfunction

  // Row-major linear address of cell (r,c) in an (n+1)x(n+1) matrix.
  function automatic logic [63:0] cell_addr(input int n, input logic [63:0] r,
                                            input logic [63:0] c);
    return r * 64'(n + 1) + c;
  endfunction

endpackage

// File: rtl/wis_index_to_addr.sv
// Combinational (r,c) -> r*(N+1)+c, zero-extended to the address width.
module wis_index_to_addr
  import wis_pkg::*;
#(
  parameter int N  = 5,
  parameter int IW = idx_w(N),
  parameter int AW = addr_w(N)
) (
  input  logic [IW-1:0] r,
  input  logic [IW-1:0] c,
  output logic [AW-1:0] addr
);

  // Constant multiply by the row pitch plus the column offset.
  assign addr = AW'(cell_addr(N, 64'(r), 64'(c)));

endmodule

// File: rtl/writing_index_score.sv
// Score-RAM write-port manager for the Needleman-Wunsch array.
// Chooses between the init sequencer (row 0 / column 0 gap scores) and the fill
// datapath, giving init priority, and registers one write per clock.
// Optional build macro WIS_BOUNDS_CHECK_EN suppresses writes whose index exceeds N.
module writing_index_score
  import wis_pkg::*;
#(
  parameter int N           = 5,
  parameter int BitAddr     = idx_w(N) - 1,
  parameter int addr_lenght = addr_w(N) - 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_ins,
  input  logic                      en_init,
  input  logic                      hit,
  input  logic [BitAddr:0]          i,
  input  logic [BitAddr:0]          j,
  input  logic [BitAddr:0]          addr_init,
  input  logic signed [SCORE_W-1:0] max,
  input  logic signed [SCORE_W-1:0] data_init,
  output logic [addr_lenght:0]      addr_out,
  output logic signed [SCORE_W-1:0] data_out,
  output logic                      we
);

  localparam int IW = BitAddr + 1;
  localparam int AW = addr_lenght + 1;

  logic [IW-1:0]             init_r;
  logic [IW-1:0]             init_c;
  logic [AW-1:0]             init_addr;
  logic [AW-1:0]             fill_addr;
  logic                      init_ok;
  logic                      fill_ok;
  logic                      req_vld;
  logic [AW-1:0]             req_addr;
  logic signed [SCORE_W-1:0] req_data;

  logic [AW-1:0]             addr_p0;
  logic signed [SCORE_W-1:0] data_p0;
  logic                      vld_p0;

  // Init target: hit=0 selects row-0 cell (0,k), hit=1 selects column-0 cell (k,0).
  always_comb begin
    init_r = '0;
    init_c = '0;
    if (hit) begin
      init_r = addr_init;
    end else begin
      init_c = addr_init;
    end
  end

  wis_index_to_addr #(.N(N), .IW(IW), .AW(AW)) u_init_addr (
    .r    (init_r),
    .c    (init_c),
    .addr (init_addr)
  );

  wis_index_to_addr #(.N(N), .IW(IW), .AW(AW)) u_fill_addr (
    .r    (i),
    .c    (j),
    .addr (fill_addr)
  );

`ifdef WIS_BOUNDS_CHECK_EN
  localparam logic [IW-1:0] N_IDX = IW'(N);
  // Any index past N would land outside the matrix: refuse the write.
  assign init_ok = (addr_init <= N_IDX);
  assign fill_ok = (i <= N_IDX) && (j <= N_IDX);
`else
  assign init_ok = 1'b1;
  assign fill_ok = 1'b1;
`endif

  // Source mux: init wins; a simultaneous fill request is dropped, not queued.
  always_comb begin
    req_vld  = 1'b0;
    req_addr = '0;
    req_data = '0;
    if (en_init) begin
      req_vld  = init_ok;
      req_addr = init_addr;
      req_data = data_init;
    end else if (en_ins) begin
      req_vld  = fill_ok;
      req_addr = fill_addr;
      req_data = max;
    end
  end

  // Stage p0: output register bank; address/data only move on an accepted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      addr_p0 <= '0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= req_vld;
      if (req_vld) begin
        addr_p0 <= req_addr;
        data_p0 <= req_data;
      end
    end
  end

  assign we       = vld_p0;
  assign addr_out = addr_p0;
  assign data_out = data_p0;

endmodule

// File: tb/tb_writing_index_score.sv
// Bench for writing_index_score (N=5): directed cases followed by random traffic
// compared against a behavioural model of the score-RAM write port.
module tb_writing_index_score;

  localparam int N = 5;
`ifdef WIS_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en_ins;
  logic        en_init;
  logic        hit;
  logic [3:0]  i;
  logic [3:0]  j;
  logic [3:0]  addr_init;
  logic [8:0]  max;
  logic [8:0]  data_init;
  logic [35:0] addr_out;
  logic [8:0]  data_out;
  logic        we;

  int total = 0;
  int bad   = 0;

  // Expected outputs as the score RAM should see them.
  logic [63:0] m_addr = '0;
  logic [63:0] m_data = '0;
  logic [63:0] m_we   = '0;

  writing_index_score #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_ins    (en_ins),
    .en_init   (en_init),
    .hit       (hit),
    .i         (i),
    .j         (j),
    .addr_init (addr_init),
    .max       (max),
    .data_init (data_init),
    .addr_out  (addr_out),
    .data_out  (data_out),
    .we        (we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [63:0] ea, input logic [63:0] ed,
                         input logic [63:0] ew);
    chk({tag, "_addr"}, 64'(addr_out), ea);
    chk({tag, "_data"}, 64'(data_out), ed);
    chk({tag, "_we"},   64'(we),       ew);
  endtask

  // Reference: what one rising edge does to the write port given the current inputs.
  task automatic model_edge();
    int r;
    int c;
    int d;
    bit go;
    r = 0; c = 0; d = 0; go = 1'b0;
    if (en_init) begin
      go = !BC || (int'(addr_init) <= N);
      if (hit) r = int'(addr_init);
      else     c = int'(addr_init);
      d = int'(data_init);
    end else if (en_ins) begin
      go = !BC || ((int'(i) <= N) && (int'(j) <= N));
      r = int'(i);
      c = int'(j);
      d = int'(max);
    end
    m_we = 64'(go);
    if (go) begin
      m_addr = 64'(r * (N + 1) + c);
      m_data = 64'(d);
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit ei, input bit ef, input bit h, input int ai,
                        input int di, input int ii, input int jj, input int mx);
    en_init   = ei;
    en_ins    = ef;
    hit       = h;
    addr_init = 4'(ai);
    data_init = 9'(di);
    i         = 4'(ii);
    j         = 4'(jj);
    max       = 9'(mx);
  endtask

  initial begin
    // Asynchronous reset with random inputs, before any clock edge.
    rst = 1'b0;
    set_in($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 5), $urandom, $urandom_range(0, 5), $urandom_range(0, 5),
           $urandom);
    #1 rst = 1'b1;
    #1;
    chk_out("reset", 64'd0, 64'd0, 64'd0);
    @(negedge clk);
    chk_out("reset_hold", 64'd0, 64'd0, 64'd0);
    rst = 1'b0;

    set_in(1, 0, 0, 3, 9'h056, 0, 0, 0);
    cycle();
    chk_out("init_row", 64'd3, 64'h056, 64'd1);

    set_in(1, 0, 1, 3, 9'h1F6, 0, 0, 0);
    cycle();
    chk_out("init_col", 64'd18, 64'h1F6, 64'd1);

    set_in(0, 1, 0, 0, 0, 2, 5, 9'h0AC);
    cycle();
    chk_out("fill_2_5", 64'd17, 64'h0AC, 64'd1);

    set_in(0, 1, 0, 0, 0, 5, 5, 9'h0AC);
    cycle();
    chk_out("fill_5_5", 64'd35, 64'h0AC, 64'd1);

    set_in(1, 1, 0, 1, 9'h123, 4, 4, 9'h0FF);
    cycle();
    chk_out("priority", 64'd1, 64'h123, 64'd1);

    set_in(0, 0, 0, 1, 9'h123, 4, 4, 9'h0FF);
    cycle();
    chk_out("idle", 64'd1, 64'h123, 64'd0);

    set_in(0, 1, 0, 0, 0, 6, 0, 9'h055);
    cycle();
    if (BC) chk_out("bounds_fill", 64'd1, 64'h123, 64'd0);
    else    chk_out("bounds_fill", 64'd36, 64'h055, 64'd1);

    // Reset between edges while a request is pending: outputs clear at once.
    set_in(0, 1, 0, 0, 0, 1, 2, 9'h1AA);
    #2 rst = 1'b1;
    #1;
    chk_out("mid_reset", 64'd0, 64'd0, 64'd0);
    m_addr = '0; m_data = '0; m_we = '0;
    #1 rst = 1'b0;
    cycle();
    chk_out("after_reset", 64'd8, 64'h1AA, 64'd1);

    // Random traffic, including out-of-range indices, against the model.
    for (int n = 0; n < 300; n++) begin
      set_in(($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom);
      cycle();
      chk_out("random", m_addr, m_data, m_we);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
